rom_loader: RTL and testbench

//  Program loader for the instruction ROM. Receives a framed byte stream, packs it into 32-bit words,
//  and writes them into the ROM write port from word 0 upward. Holds the CPU in reset until a complete,

---
 rtl/rom_loader_pkg.sv | 12 +
 rtl/rom_loader_if.sv | 14 +
 rtl/rom_loader_packer.sv | 36 +++
 rtl/rom_loader.sv | 80 ++++++++
 tb/tb_rom_loader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared state encoding, frame widths and helpers for the ROM loader
package rom_loader_pkg;
  localparam int BYTE_W = 8;
  localparam int INST_W = 32;
  localparam int LEN_W  = 16;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [INST_W-1:0] inst_t;
  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERR} state_t;
  function automatic logic loading(input state_t s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  endfunction
endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte stream in, ROM write port and CPU control out of the loader
//   in_valid/in_data/in_ready : framed byte stream (master drives valid/data)
//   reload                    : restart pulse from master
//   rom_we/rom_addr/rom_wdata : ROM write port (slave drives)
//   cpu_rst/done/error        : CPU reset and load status (slave drives)
interface rom_loader_if #(parameter int ADDR_W = 10);
  import rom_loader_pkg::*;
  logic in_valid, in_ready, reload, rom_we, cpu_rst, done, error;
  byte_t in_data;
  logic [ADDR_W-1:0] rom_addr;
  inst_t rom_wdata;
  modport master(output in_valid, in_data, reload, input in_ready, rom_we, rom_addr, rom_wdata, cpu_rst, done, error);
  modport slave(input in_valid, in_data, reload, output in_ready, rom_we, rom_addr, rom_wdata, cpu_rst, done, error);
endinterface

// File: rtl/rom_loader_packer.sv
// rom_loader_packer: packs accepted payload bytes big-endian into 32-bit words
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (reload)
//   shift, din : accept one payload byte
//   cnt        : bytes already held of the current word
//   word_valid : one-cycle pulse, word holds a complete instruction
//   word       : shift register, first byte ends up in bits[31:24]
module rom_loader_packer
  import rom_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift,
  input  byte_t      din,
  output logic [1:0] cnt,
  output logic       word_valid,
  output inst_t      word
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      word_valid <= 1'b0;
      word <= '0;
    end else if (clr) begin
      cnt <= '0;
      word_valid <= 1'b0;
      word <= '0;
    end else begin
      word_valid <= shift && cnt == 2'd3;
      if (shift) begin
        cnt <= cnt + 2'd1;
        word <= {word[INST_W-BYTE_W-1:0], din};
      end
    end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: loads a framed, checksummed byte stream into the instruction ROM and releases the CPU
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : byte stream (in_valid/in_data/in_ready), reload pulse,
//                ROM write port (rom_we/rom_addr/rom_wdata), cpu_rst/done/error status
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4
) (
  input logic        clk,
  input logic        rst_n,
  rom_loader_if.slave bus
);
  localparam logic [LEN_W:0] CAP = (LEN_W+1)'(1) << ADDR_W;
  state_t state, nxt;
  logic rdy, acc, last, word_valid;
  logic [1:0] bcnt;
  logic [LEN_W-1:0] len, widx;
  logic [LEN_W:0] len_full;
  logic [7:0] hcnt;
  byte_t sum;
  rom_loader_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.reload),
    .shift     (acc && state == S_DATA),
    .din       (bus.in_data),
    .cnt       (bcnt),
    .word_valid(word_valid),
    .word      (bus.rom_wdata)
  );
  // rdy is registered so in_ready stays low for the first cycle out of reset
  assign bus.in_ready = rdy && !bus.reload;
  assign acc = bus.in_valid && bus.in_ready;
  assign len_full = {1'b0, len[LEN_W-1:BYTE_W], bus.in_data};
  // last byte of the last word: the write itself lands in S_CSUM one cycle later
  assign last = bcnt == 2'd3 && widx == len - LEN_W'(1);
  assign bus.rom_we = word_valid;
  assign bus.rom_addr = widx[ADDR_W-1:0];
  assign bus.cpu_rst = state != S_RUN;
  assign bus.done = state == S_RUN;
  assign bus.error = state == S_ERR;
  always_comb begin
    nxt = state;
    if (bus.reload) nxt = S_LEN_HI;
    else
      case (state)
        S_LEN_HI: nxt = acc ? S_LEN_LO : state;
        S_LEN_LO: nxt = !acc ? state : len_full > CAP ? S_ERR : len_full == '0 ? S_CSUM : S_DATA;
        S_DATA:   nxt = acc && last ? S_CSUM : state;
        S_CSUM:   nxt = !acc ? state : bus.in_data == sum ? S_HOLD : S_ERR;
        S_HOLD:   nxt = hcnt == 8'(RST_HOLD - 1) ? S_RUN : state;
        default:  nxt = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_LEN_HI;
      rdy <= 1'b0;
      len <= '0;
      widx <= '0;
      sum <= '0;
      hcnt <= '0;
    end else begin
      state <= nxt;
      rdy <= loading(nxt);
      hcnt <= state == S_HOLD && !bus.reload ? hcnt + 8'd1 : 8'd0;
      if (bus.reload) begin
        len <= '0;
        widx <= '0;
        sum <= '0;
      end else begin
        if (acc && state == S_LEN_HI) len[LEN_W-1:BYTE_W] <= bus.in_data;
        if (acc && state == S_LEN_LO) len[BYTE_W-1:0] <= bus.in_data;
        if (acc && state != S_CSUM) sum <= sum + bus.in_data;
        if (word_valid) widx <= widx + LEN_W'(1);
      end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed + randomized frame loads checked against a word-array ROM model
module tb_rom_loader;
  import rom_loader_pkg::*;
  localparam int ADDR_W = 10, RST_HOLD = 4, DEPTH = 1 << ADDR_W;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  int nwr = 0, exp_nwr = 0;
  logic [31:0] rom [DEPTH];
  logic [31:0] exp_rom [DEPTH];
  logic [31:0] words [$];
  rom_loader_if #(.ADDR_W(ADDR_W)) bus ();
  rom_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.rom_we) begin
      rom[bus.rom_addr] <= bus.rom_wdata;
      nwr <= nwr + 1;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic send(input byte_t b, input int gap);
    int t = 0;
    while (gap > 0 && $urandom_range(99) < gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = byte_t'($urandom);
  endtask
  // sends LEN, payload of words[], CSUM (+bad); stops after cut payload bytes when cut >= 0
  task automatic send_frame(input int bad, input int gap, input int cut);
    int n = words.size();
    byte_t s, b;
    s = byte_t'(n >> 8) + byte_t'(n);
    send(byte_t'(n >> 8), gap);
    send(byte_t'(n), gap);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        if (cut >= 0 && 4 * i + k >= cut) return;
        b = byte_t'(words[i] >> (24 - 8 * k));
        s += b;
        send(b, gap);
        if (k == 3) begin
          chk("rom_we", bus.rom_we, 1);
          chk("rom_addr", bus.rom_addr, i);
          chk("rom_wdata", bus.rom_wdata, words[i]);
          exp_rom[i] = words[i];
          exp_nwr++;
        end
      end
    send(s + byte_t'(bad), gap);
  endtask
  task automatic new_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask
  task automatic expect_release();
    for (int i = 1; i <= RST_HOLD; i++) begin
      chk("cpu_rst_hold", bus.cpu_rst, 1);
      chk("done_hold", bus.done, 0);
      @(negedge clk);
    end
    chk("cpu_rst_run", bus.cpu_rst, 0);
    chk("done_run", bus.done, 1);
    chk("error_run", bus.error, 0);
    chk("in_ready_run", bus.in_ready, 0);
  endtask
  task automatic expect_error();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      chk("error", bus.error, 1);
      chk("cpu_rst_err", bus.cpu_rst, 1);
      chk("done_err", bus.done, 0);
      chk("in_ready_err", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic do_reload();
    bus.reload = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hFF;
    #1 chk("in_ready_reload", bus.in_ready, 0);
    @(negedge clk);
    bus.reload = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rom_we_after_reload", bus.rom_we, 0);
    chk("cpu_rst_after_reload", bus.cpu_rst, 1);
    chk("done_after_reload", bus.done, 0);
    chk("error_after_reload", bus.error, 0);
    chk("in_ready_after_reload", bus.in_ready, 1);
    @(negedge clk);
  endtask
  task automatic cmp_rom();
    chk("write_count", nwr, exp_nwr);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("rom[%0d]", i), rom[i], exp_rom[i]);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rom_we", bus.rom_we, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_rom_wdata", bus.rom_wdata, 0);
    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.reload = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] <= 32'hA5000000 + i;
      exp_rom[i] = 32'hA5000000 + i;
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    // valid two-word image
    words = '{32'h34010001, 32'h34010002};
    send_frame(0, 0, -1);
    expect_release();
    do_reload();
    // same image, corrupted checksum
    send_frame(1, 0, -1);
    expect_error();
    do_reload();
    // empty image
    words.delete();
    send_frame(0, 0, -1);
    expect_release();
    chk("n0_writes", nwr, exp_nwr);
    do_reload();
    // one word over capacity: rejected right after LEN_LO
    new_words(DEPTH + 1);
    send_frame(0, 0, 0);
    expect_error();
    chk("overflow_writes", nwr, exp_nwr);
    do_reload();
    // 92 random words with random stalls
    new_words(92);
    send_frame(0, 50, -1);
    expect_release();
    cmp_rom();
    do_reload();
    // exactly full capacity
    new_words(DEPTH);
    send_frame(0, 0, -1);
    expect_release();
    cmp_rom();
    do_reload();
    // abort during word 2 with reload, then a fresh image
    new_words(8);
    send_frame(0, 0, 10);
    do_reload();
    new_words(5);
    send_frame(0, 20, -1);
    expect_release();
    cmp_rom();
    do_reload();
    // asynchronous reset mid-load
    new_words(8);
    send_frame(0, 0, 6);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_words(3);
    send_frame(0, 0, -1);
    expect_release();
    cmp_rom();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
